// File: rtl/pic24_fetch_unit_if.sv
// Bus bundle between the PIC24 fetch stage, program memory, decode and the redirect source.
// The fetch unit takes the master view; the memory/decode/redirect environment takes the slave view.
interface pic24_fetch_unit_if #(
    parameter int PC_WIDTH = 23
);
    logic                o_pm_rd;
    logic [PC_WIDTH-1:0] o_pm_addr;
    logic [23:0]         i_pm_rdata;
    logic                i_pm_valid;
    logic                o_inst_valid;
    logic [23:0]         o_inst;
    logic [PC_WIDTH-1:0] o_inst_pc;
    logic                i_inst_ready;
    logic                i_redirect;
    logic [PC_WIDTH-1:0] i_redirect_pc;

    modport master (
        output o_pm_rd, o_pm_addr, o_inst_valid, o_inst, o_inst_pc,
        input  i_pm_rdata, i_pm_valid, i_inst_ready, i_redirect, i_redirect_pc
    );

    modport slave (
        input  o_pm_rd, o_pm_addr, o_inst_valid, o_inst, o_inst_pc,
        output i_pm_rdata, i_pm_valid, i_inst_ready, i_redirect, i_redirect_pc
    );
endinterface

// File: rtl/pic24_fetch_unit.sv
// PIC24 instruction fetch stage: at most one outstanding program-memory read,
// a {word, pc} FIFO toward decode, and a full flush on redirect.
module pic24_fetch_unit #(
    parameter int                  PC_WIDTH     = 23,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = {PC_WIDTH{1'b0}},
    parameter int                  QDEPTH       = 4
) (
    input  logic               i_clk_50M,
    input  logic               i_rstn,
    pic24_fetch_unit_if.master bus
);
    localparam int               PTR_W      = $clog2(QDEPTH);
    localparam int               CNT_W      = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(QDEPTH);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic                run_r;
    logic [PC_WIDTH-1:0] fetch_pc_r;
    logic [PC_WIDTH-1:0] req_pc_r;
    logic [23:0]         word_mem_r [QDEPTH];
    logic [PC_WIDTH-1:0] pc_mem_r   [QDEPTH];
    logic [PTR_W-1:0]    wr_ptr_r;
    logic [PTR_W-1:0]    rd_ptr_r;
    logic [CNT_W-1:0]    count_r;
    logic                issue_s;
    logic                push_s;
    logic                pop_s;
    logic [PC_WIDTH-1:0] redirect_pc_s;

    assign redirect_pc_s = {bus.i_redirect_pc[PC_WIDTH-1:1], 1'b0};
    assign pop_s         = (count_r != {CNT_W{1'b0}}) && bus.i_inst_ready;

    // Next-state decode, request issue and push qualification
    always_comb begin
        state_s = state_r;
        issue_s = 1'b0;
        push_s  = 1'b0;
        case (state_r)
            ST_FETCH: begin
                // run_r holds off the first request until reset release has been sampled
                issue_s = run_r && (count_r < FULL_COUNT) && !bus.i_redirect;
                if (issue_s) begin
                    state_s = ST_WAIT;
                end else begin
                    state_s = ST_FETCH;
                end
            end
            ST_WAIT: begin
                if (bus.i_pm_valid) begin
                    push_s  = !bus.i_redirect;
                    state_s = ST_FETCH;
                end else if (bus.i_redirect) begin
                    state_s = ST_FLUSH;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_FLUSH: begin
                // the returning word is stale whether or not another redirect arrives with it
                if (bus.i_pm_valid) begin
                    state_s = ST_FETCH;
                end else begin
                    state_s = ST_FLUSH;
                end
            end
            default: begin
                state_s = ST_FETCH;
            end
        endcase
    end

    assign bus.o_pm_rd      = issue_s;
    assign bus.o_pm_addr    = (state_r == ST_FETCH) ? fetch_pc_r : req_pc_r;
    assign bus.o_inst_valid = (count_r != {CNT_W{1'b0}});
    assign bus.o_inst       = word_mem_r[rd_ptr_r];
    assign bus.o_inst_pc    = pc_mem_r[rd_ptr_r];

    // State register and post-reset run flag
    always_ff @(posedge i_clk_50M or negedge i_rstn) begin
        if (!i_rstn) begin
            state_r <= ST_FETCH;
            run_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            run_r   <= 1'b1;
        end
    end

    // Fetch and in-flight request program counters
    always_ff @(posedge i_clk_50M or negedge i_rstn) begin
        if (!i_rstn) begin
            fetch_pc_r <= RESET_VECTOR;
            req_pc_r   <= RESET_VECTOR;
        end else if (bus.i_redirect) begin
            fetch_pc_r <= redirect_pc_s;
        end else if (issue_s) begin
            req_pc_r   <= fetch_pc_r;
            fetch_pc_r <= fetch_pc_r + PC_WIDTH'(2);
        end
    end

    // FIFO storage; cleared on reset so the head reads as zero
    always_ff @(posedge i_clk_50M or negedge i_rstn) begin
        if (!i_rstn) begin
            for (int i = 0; i < QDEPTH; i++) begin
                word_mem_r[i] <= 24'h000000;
                pc_mem_r[i]   <= {PC_WIDTH{1'b0}};
            end
        end else if (push_s) begin
            word_mem_r[wr_ptr_r] <= bus.i_pm_rdata;
            pc_mem_r[wr_ptr_r]   <= req_pc_r;
        end
    end

    // FIFO pointers and occupancy; redirect empties the queue outright
    always_ff @(posedge i_clk_50M or negedge i_rstn) begin
        if (!i_rstn) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else if (bus.i_redirect) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end
endmodule

// File: tb/tb_pic24_fetch_unit.sv
// Self-checking bench for pic24_fetch_unit: a latency-programmable memory responder and a
// transaction-level model (expected request / delivery PCs, queue occupancy) judge every cycle.
module tb_pic24_fetch_unit;
    localparam int            PW  = 23;
    localparam int            QD  = 4;
    localparam logic [PW-1:0] RV  = 23'h000000;
    localparam logic [PW-1:0] ZPC = 23'h000000;

    logic clk;
    logic rstn;
    int   errors;
    int   checks;

    // memory responder and reference model state
    int            mem_lat;
    bit            pend;
    bit            drop;
    int            pend_cnt;
    logic [PW-1:0] pend_addr;
    int            m_cnt;
    logic [PW-1:0] exp_req;
    logic [PW-1:0] exp_next;
    bit            stray;
    bit            prev_stall;
    logic [23:0]   prev_inst;
    logic [PW-1:0] prev_pc;
    logic [PW-1:0] req_log[$];
    logic [PW-1:0] del_log[$];

    pic24_fetch_unit_if #(.PC_WIDTH(PW)) bus ();

    pic24_fetch_unit #(
        .PC_WIDTH    (PW),
        .RESET_VECTOR(RV),
        .QDEPTH      (QD)
    ) dut (
        .i_clk_50M(clk),
        .i_rstn   (rstn),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

    function automatic logic [23:0] word_of(input logic [PW-1:0] a);
        return {a[7:0], 16'h0000} ^ {1'b0, a} ^ 24'hA53C96;
    endfunction

    task automatic model_reset();
        pend       = 1'b0;
        drop       = 1'b0;
        pend_cnt   = 0;
        m_cnt      = 0;
        exp_req    = RV;
        exp_next   = RV;
        stray      = 1'b0;
        prev_stall = 1'b0;
        req_log.delete();
        del_log.delete();
    endtask

    task automatic idle_inputs();
        bus.i_pm_valid    = 1'b0;
        bus.i_pm_rdata    = 24'h000000;
        bus.i_inst_ready  = 1'b0;
        bus.i_redirect    = 1'b0;
        bus.i_redirect_pc = ZPC;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        model_reset();
        @(posedge clk);
        @(negedge clk);
    endtask

    // one clock: drive inputs, judge outputs against the model, advance the model at the edge
    task automatic cycle(input bit redir, input logic [PW-1:0] rpc, input bit rdy);
        bit            vnow;
        bit            hs;
        bit            exp_rd;
        bit            push;
        bit            issued;
        logic [PW-1:0] iss_addr;
        vnow              = pend && (pend_cnt == 0);
        bus.i_redirect    = redir;
        bus.i_redirect_pc = rpc;
        bus.i_inst_ready  = rdy;
        bus.i_pm_valid    = vnow || (stray && !pend);
        bus.i_pm_rdata    = vnow ? word_of(pend_addr) : 24'($urandom);
        #1;
        checks++;
        if (bus.o_inst_valid !== (m_cnt > 0)) begin
            errors++;
            $display("FAIL inst_valid: got %b want %b (queued %0d)", bus.o_inst_valid, (m_cnt > 0), m_cnt);
        end
        if (prev_stall && m_cnt > 0) begin
            checks++;
            if (bus.o_inst !== prev_inst || bus.o_inst_pc !== prev_pc) begin
                errors++;
                $display("FAIL head_stable: got %h@%h want %h@%h", bus.o_inst, bus.o_inst_pc, prev_inst, prev_pc);
            end
        end
        hs = (m_cnt > 0) && rdy;
        if (hs) begin
            checks++;
            if (bus.o_inst_pc !== exp_next || bus.o_inst !== word_of(exp_next)) begin
                errors++;
                $display("FAIL deliver: got %h@%h want %h@%h", bus.o_inst, bus.o_inst_pc, word_of(exp_next), exp_next);
            end
            del_log.push_back(bus.o_inst_pc);
            exp_next = exp_next + PW'(2);
        end
        exp_rd = !pend && (m_cnt < QD) && !redir;
        checks++;
        if (bus.o_pm_rd !== exp_rd) begin
            errors++;
            $display("FAIL pm_rd: got %b want %b", bus.o_pm_rd, exp_rd);
        end
        issued   = (bus.o_pm_rd === 1'b1);
        iss_addr = bus.o_pm_addr;
        if (issued) begin
            checks++;
            if (iss_addr !== exp_req) begin
                errors++;
                $display("FAIL pm_addr: got %h want %h", iss_addr, exp_req);
            end
            req_log.push_back(iss_addr);
        end
        prev_stall = (m_cnt > 0) && !rdy;
        prev_inst  = bus.o_inst;
        prev_pc    = bus.o_inst_pc;
        @(posedge clk);
        push = vnow && !drop && !redir;
        if (vnow) begin
            pend = 1'b0;
            drop = 1'b0;
        end
        if (redir) begin
            m_cnt      = 0;
            exp_req    = {rpc[PW-1:1], 1'b0};
            exp_next   = {rpc[PW-1:1], 1'b0};
            prev_stall = 1'b0;
            if (pend) drop = 1'b1;
        end else begin
            m_cnt = m_cnt + int'(push) - int'(hs);
        end
        if (issued) begin
            pend      = 1'b1;
            pend_addr = iss_addr;
            pend_cnt  = mem_lat - 1;
            exp_req   = iss_addr + PW'(2);
        end else if (pend) begin
            pend_cnt--;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.o_pm_rd !== 1'b0) begin errors++; $display("FAIL rst_pm_rd: got %b want 0", bus.o_pm_rd); end
        checks++;
        if (bus.o_pm_addr !== RV) begin errors++; $display("FAIL rst_pm_addr: got %h want %h", bus.o_pm_addr, RV); end
        checks++;
        if (bus.o_inst_valid !== 1'b0) begin errors++; $display("FAIL rst_inst_valid: got %b want 0", bus.o_inst_valid); end
        checks++;
        if (bus.o_inst !== 24'h000000 || bus.o_inst_pc !== ZPC) begin
            errors++; $display("FAIL rst_inst: got %h@%h want 0@0", bus.o_inst, bus.o_inst_pc);
        end
        rstn = 1'b1;
        model_reset();
        mem_lat = 1;
        bus.i_pm_valid   = 1'b1;
        bus.i_pm_rdata   = 24'h123456;
        bus.i_inst_ready = 1'b1;
        #1;
        checks++;
        if (bus.o_pm_rd !== 1'b0) begin errors++; $display("FAIL release_pm_rd: got %b want 0", bus.o_pm_rd); end
        @(posedge clk);
        @(negedge clk);
        stray = 1'b1;
        cycle(1'b0, ZPC, 1'b1);
        stray = 1'b0;
        checks++;
        if (req_log.size() != 1 || req_log[0] !== RV) begin
            errors++; $display("FAIL first_req: got %0d requests want 1 at %h", req_log.size(), RV);
        end
        repeat (6) cycle(1'b0, ZPC, 1'b1);
    endtask

    task automatic test_stream();
        do_reset();
        mem_lat = 1;
        repeat (40) cycle(1'b0, ZPC, 1'b1);
        checks++;
        if (del_log.size() != 19) begin
            errors++; $display("FAIL stream_rate: got %0d deliveries want 19", del_log.size());
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (req_log[i] !== PW'(2 * i)) begin
                errors++; $display("FAIL stream_req%0d: got %h want %h", i, req_log[i], PW'(2 * i));
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        mem_lat = 1;
        repeat (20) cycle(1'b0, ZPC, 1'b0);
        checks++;
        if (req_log.size() != 4) begin
            errors++; $display("FAIL bp_requests: got %0d want 4", req_log.size());
        end
        repeat (20) cycle(1'b0, ZPC, 1'b1);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (del_log[i] !== PW'(2 * i)) begin
                errors++; $display("FAIL bp_pop%0d: got %h want %h", i, del_log[i], PW'(2 * i));
            end
        end
        checks++;
        if (req_log[4] !== 23'h000008) begin
            errors++; $display("FAIL bp_resume: got %h want 000008", req_log[4]);
        end
    endtask

    task automatic test_redirect_inflight();
        int guard;
        int base_req;
        int base_del;
        do_reset();
        mem_lat = 3;
        guard   = 0;
        while (!(req_log.size() > 0 && req_log[req_log.size() - 1] === 23'h000010) && guard < 200) begin
            cycle(1'b0, ZPC, 1'b1);
            guard++;
        end
        checks++;
        if (guard >= 200) begin errors++; $display("FAIL inflight_reach: no request at 000010 within bound"); end
        base_req = req_log.size();
        base_del = del_log.size();
        cycle(1'b1, 23'h001235, 1'b1);
        repeat (30) cycle(1'b0, ZPC, 1'b1);
        checks++;
        if (req_log.size() <= base_req || req_log[base_req] !== 23'h001234) begin
            errors++; $display("FAIL inflight_req: got %h want 001234", req_log[base_req]);
        end
        checks++;
        if (del_log.size() <= base_del || del_log[base_del] !== 23'h001234) begin
            errors++; $display("FAIL inflight_del: got %h want 001234", del_log[base_del]);
        end
    endtask

    task automatic test_redirect_collide();
        int guard;
        int base_req;
        int base_del;
        do_reset();
        mem_lat = 1;
        guard   = 0;
        while (!(pend && pend_cnt == 0 && m_cnt >= 1) && guard < 50) begin
            cycle(1'b0, ZPC, 1'b0);
            guard++;
        end
        checks++;
        if (guard >= 50) begin errors++; $display("FAIL collide_reach: setup not reached within bound"); end
        base_del = del_log.size();
        cycle(1'b1, 23'h000457, 1'b1);
        checks++;
        if (del_log.size() != base_del + 1 || del_log[base_del] !== RV) begin
            errors++; $display("FAIL collide_hs: got %0d pops want 1 at %h", del_log.size() - base_del, RV);
        end
        base_req = req_log.size();
        cycle(1'b0, ZPC, 1'b1);
        checks++;
        if (req_log.size() != base_req + 1 || req_log[base_req] !== 23'h000456) begin
            errors++; $display("FAIL collide_req: got %0d requests want 1 at 000456", req_log.size() - base_req);
        end
        repeat (10) cycle(1'b0, ZPC, 1'b1);
        checks++;
        if (del_log[base_del + 1] !== 23'h000456) begin
            errors++; $display("FAIL collide_del: got %h want 000456", del_log[base_del + 1]);
        end
    endtask

    task automatic test_wrap();
        int base_req;
        logic [PW-1:0] want [3];
        want[0] = 23'h7FFFFC;
        want[1] = 23'h7FFFFE;
        want[2] = 23'h000000;
        do_reset();
        mem_lat = 1;
        repeat (5) cycle(1'b0, ZPC, 1'b1);
        base_req = req_log.size();
        cycle(1'b1, 23'h7FFFFC, 1'b1);
        repeat (20) cycle(1'b0, ZPC, 1'b1);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (req_log[base_req + i] !== want[i]) begin
                errors++; $display("FAIL wrap%0d: got %h want %h", i, req_log[base_req + i], want[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int guard;
        do_reset();
        mem_lat = 3;
        guard   = 0;
        while (!(m_cnt == 3 && pend) && guard < 100) begin
            cycle(1'b0, ZPC, 1'b0);
            guard++;
        end
        checks++;
        if (guard >= 100) begin errors++; $display("FAIL midrst_reach: wait state not reached within bound"); end
        #2;
        rstn = 1'b0;
        bus.i_pm_valid = 1'b0;
        #1;
        checks++;
        if (bus.o_pm_rd !== 1'b0 || bus.o_pm_addr !== RV) begin
            errors++; $display("FAIL midrst_pm: got rd=%b addr=%h want rd=0 addr=%h", bus.o_pm_rd, bus.o_pm_addr, RV);
        end
        checks++;
        if (bus.o_inst_valid !== 1'b0 || bus.o_inst !== 24'h000000 || bus.o_inst_pc !== ZPC) begin
            errors++; $display("FAIL midrst_inst: got v=%b %h@%h want v=0 0@0", bus.o_inst_valid, bus.o_inst, bus.o_inst_pc);
        end
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        model_reset();
        mem_lat = 1;
        bus.i_pm_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        stray = 1'b1;
        cycle(1'b0, ZPC, 1'b1);
        stray = 1'b0;
        repeat (8) cycle(1'b0, ZPC, 1'b1);
        checks++;
        if (req_log.size() == 0 || req_log[0] !== RV) begin
            errors++; $display("FAIL midrst_req: got %h want %h", req_log[0], RV);
        end
        checks++;
        if (del_log.size() == 0 || del_log[0] !== RV) begin
            errors++; $display("FAIL midrst_del: got %h want %h", del_log[0], RV);
        end
    endtask

    task automatic test_random();
        bit            rdy;
        bit            redir;
        logic [PW-1:0] rpc;
        do_reset();
        for (int i = 0; i < 800; i++) begin
            if (!pend) mem_lat = $urandom_range(1, 3);
            rdy   = ($urandom_range(0, 3) != 0);
            redir = ($urandom_range(0, 24) == 0);
            rpc   = PW'($urandom);
            cycle(redir, rpc, rdy);
        end
        checks++;
        if (del_log.size() < 100) begin
            errors++; $display("FAIL random_progress: got %0d deliveries want at least 100", del_log.size());
        end
    endtask

    initial begin
        errors  = 0;
        checks  = 0;
        mem_lat = 1;
        rstn    = 1'b0;
        idle_inputs();
        model_reset();
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_inflight();
        test_redirect_collide();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
